reg_bank_p8_loader: RTL and testbench
=====================================

REG_BANK_P8_LOADER -- requirements
Module: reg_bank_p8_loader

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  load request, sampled only in Idle.
REQ-004 SHALL have port: mask  input  8  bit n set = load register n; sampled with start.
REQ-005 SHALL have port: data  input  64  byte n = data[8n+7:8n] = value for register n; sampled with start.
REQ-006 SHALL have port: inst  output  12  instruction to the 8-register bank: [11:8] opcode, [7:0] immediate.
REQ-007 SHALL have port: inst_en  output  1  inst valid this cycle.
REQ-008 SHALL have port: busy  output  1  high from the accepting edge until the done edge.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-010 Opcodes SHALL be: NOP = 4'h0; LDn = 4'h1+n for n in 0..7; no other opcode SHALL ever be emitted.
REQ-011 States SHALL be Idle, Issue, Done; all outputs SHALL be registered.
REQ-012 Idle, start=1 at an edge: SHALL capture mask/data into internal copies, set busy=1, go to Issue; inst_en stays 0 that cycle.
REQ-013 Idle, start=0: SHALL stay Idle, inst_en=0, busy=0, done=0.
REQ-014 Issue, pending mask non-zero: each edge SHALL emit inst={LDn, byte n} with inst_en=1 for the lowest set pending bit n, then clear that bit.
REQ-015 Loads SHALL be issued in ascending register order, one per cycle, no bubbles (subject to REQ-026).
REQ-016 Issue, pending mask zero: next edge SHALL drive inst_en=0, done=1, busy=0 and go to Done.
REQ-017 Done: next edge SHALL drive done=0 and go to Idle; start is ignored in Done.
REQ-018 start while busy SHALL be ignored; mask/data changes after capture SHALL have no effect.
REQ-019 start with mask=8'h00: zero instructions; done SHALL pulse on the second edge after capture.
REQ-020 When inst_en=0, inst SHALL be 12'h000.
REQ-021 Latency, k set bits (no gap): first inst_en at edge N+1, last at N+k, done at N+k+1, where N = accepting edge.
REQ-022 An illegal state encoding SHALL return to Idle on the next edge with all outputs deasserted.

Reset
REQ-023 reset=0 SHALL immediately (asynchronously) force Idle, inst=12'h000, inst_en=0, busy=0, done=0, internal mask=0.
REQ-024 reset asserted mid-sequence SHALL abort; no further instructions after release until a new start.
REQ-025 First edge after reset release SHALL be able to accept start.

Configuration
REQ-026 Macro REG_BANK_P8_LOADER_NOP_GAP_EN defined: one NOP cycle (inst=12'h000, inst_en=1) SHALL be inserted between consecutive loads, never before the first or after the last; k loads take 2k-1 instruction cycles, done at N+2k.
REQ-027 Macro undefined: no NOP SHALL ever be emitted and timing SHALL be per REQ-021.

Verification
REQ-028 start, mask=8'h05, data byte0=8'hAB, byte2=8'h3C -> edges N+1,N+2: inst=12'h1AB, 12'h33C; done at N+3; bank reads 0=AB, 2=3C.
REQ-029 start, mask=8'hFF, data=64'h0706050403020100 -> eight cycles of inst 12'h100,12'h201,...,12'h807; busy high 9 cycles from edge N; done at N+9.
REQ-030 start, mask=8'h00 -> no inst_en; done pulse at N+2; busy high exactly from N to N+2.
REQ-031 start held high through sequence, mask changed to 8'hFF after capture of 8'h80 -> only 12'h8xx emitted, one done; second sequence begins only after Done returns to Idle.
REQ-032 reset pulled low after second load of mask 8'h0F -> outputs 0 immediately, no further inst_en after release.
REQ-033 NOP_GAP_EN defined, mask=8'h03, bytes 11,22 -> 12'h111, 12'h000 (inst_en=1), 12'h222; done at N+4.

Source files
------------

// File: rtl/reg_bank_p8_loader.sv
// Sequencer that loads up to eight bank registers by issuing LDn instructions in ascending order.
// Optional build macro REG_BANK_P8_LOADER_NOP_GAP_EN inserts one NOP between consecutive loads.
module reg_bank_p8_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  mask,
  input  logic [63:0] data,
  output logic [11:0] inst,
  output logic        inst_en,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD0 = 4'h1;

  state_t      state_q, state_d;
  logic [7:0]  pend_q, pend_d;
  logic [63:0] data_q;
  logic        empty_q, empty_d;
  logic        gap_q, gap_d;
  logic [11:0] inst_d;
  logic        inst_en_d, busy_d, done_d;
  logic        capture;
  logic [2:0]  low_idx;
  logic [7:0]  low_oh;
  logic [5:0]  byte_base;

  // Lowest pending register; the descending loop lets the smallest set index win.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) low_idx = 3'(i);
    end
  end

  assign low_oh    = pend_q & (~pend_q + 8'd1);
  assign byte_base = {low_idx, 3'b000};

  // State register plus every registered output and control flag.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pend_q  <= 8'h00;
      empty_q <= 1'b0;
      gap_q   <= 1'b0;
      inst    <= 12'h000;
      inst_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      empty_q <= empty_d;
      gap_q   <= gap_d;
      inst    <= inst_d;
      inst_en <= inst_en_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // NOTE: the payload copy has no reset; it is only read under a pending-mask bit, which reset clears.
  always_ff @(posedge clock) begin
    if (capture) data_q <= data;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = (pend_q == 8'h00 && !empty_q) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    pend_d    = pend_q;
    empty_d   = empty_q;
    gap_d     = gap_q;
    inst_d    = 12'h000;
    inst_en_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          pend_d  = mask;
          empty_d = (mask == 8'h00);
          gap_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        busy_d = 1'b1;
        if (empty_q) begin
          // An empty request spends one quiet cycle so done lands two edges after capture.
          empty_d = 1'b0;
        end else if (pend_q != 8'h00) begin
`ifdef REG_BANK_P8_LOADER_NOP_GAP_EN
          if (gap_q) begin
            inst_d    = {OP_NOP, 8'h00};
            inst_en_d = 1'b1;
            gap_d     = 1'b0;
          end else begin
            inst_d    = {OP_LD0 + {1'b0, low_idx}, data_q[byte_base +: 8]};
            inst_en_d = 1'b1;
            pend_d    = pend_q & ~low_oh;
            gap_d     = ((pend_q & ~low_oh) != 8'h00);
          end
`else
          inst_d    = {OP_LD0 + {1'b0, low_idx}, data_q[byte_base +: 8]};
          inst_en_d = 1'b1;
          pend_d    = pend_q & ~low_oh;
`endif
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_DONE: begin
        pend_d  = 8'h00;
        empty_d = 1'b0;
        gap_d   = 1'b0;
      end
      default: begin
        pend_d  = 8'h00;
        empty_d = 1'b0;
        gap_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_bank_p8_loader.sv
// Self-checking bench for reg_bank_p8_loader: directed vector table, hand sequences, random vs. model.
module tb_reg_bank_p8_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mask  = 8'h00;
  logic [63:0] data  = 64'h0;
  logic [11:0] inst;
  logic        inst_en, busy, done;

  reg_bank_p8_loader dut (
    .clock(clock), .reset(reset), .start(start), .mask(mask), .data(data),
    .inst(inst), .inst_en(inst_en), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

`ifdef REG_BANK_P8_LOADER_NOP_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] inst;
    logic        inst_en;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    string       name;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [11:0] first_inst;
    logic [11:0] last_inst;
    int          n_inst;
    int          done_edge;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t cur;
  obs_t exp_q[$];
  logic [7:0] bank [8];
  logic bad_inst = 1'b0;

  assign cur = {inst, inst_en, busy, done};

  // Simple bank model plus a sticky legality monitor on the instruction stream.
  always @(posedge clock) begin
    if (inst_en && inst[11:8] >= 4'h1 && inst[11:8] <= 4'h8) bank[inst[11:8] - 4'h1] <= inst[7:0];
    if (inst_en && inst[11:8] > 4'h8) bad_inst <= 1'b1;
    if (inst_en && inst[11:8] == 4'h0 && inst[7:0] != 8'h00) bad_inst <= 1'b1;
    if (!inst_en && inst != 12'h000) bad_inst <= 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected per-edge outputs from the accepting edge to the return to Idle.
  task automatic build_expected(input logic [7:0] m, input logic [63:0] d);
    bit first = 1'b1;
    exp_q.delete();
    exp_q.push_back('{inst: 12'h000, inst_en: 1'b0, busy: 1'b1, done: 1'b0});
    if (m == 8'h00) exp_q.push_back('{inst: 12'h000, inst_en: 1'b0, busy: 1'b1, done: 1'b0});
    for (int n = 0; n < 8; n++) begin
      if (m[n]) begin
        if (GAP && !first) exp_q.push_back('{inst: 12'h000, inst_en: 1'b1, busy: 1'b1, done: 1'b0});
        exp_q.push_back('{inst: {4'(n + 1), d[8*n +: 8]}, inst_en: 1'b1, busy: 1'b1, done: 1'b0});
        first = 1'b0;
      end
    end
    exp_q.push_back('{inst: 12'h000, inst_en: 1'b0, busy: 1'b0, done: 1'b1});
    exp_q.push_back('{inst: 12'h000, inst_en: 1'b0, busy: 1'b0, done: 1'b0});
  endtask

  task automatic run_vec(input vec_t v);
    logic [11:0] first_i = 12'h000;
    logic [11:0] last_i  = 12'h000;
    int cnt = 0, done_at = 0, busy_cnt = 0;
    start = 1'b1; mask = v.mask; data = v.data;
    step();
    if (busy) busy_cnt++;
    start = 1'b0; mask = 8'($urandom); data = {$urandom, $urandom};
    for (int j = 1; j <= 40 && done_at == 0; j++) begin
      step();
      if (busy) busy_cnt++;
      if (inst_en) begin
        if (cnt == 0) first_i = inst;
        last_i = inst;
        cnt++;
      end
      if (done) done_at = j;
    end
    step();
    check({v.name, "_n_inst"}, 64'(cnt), 64'(v.n_inst));
    check({v.name, "_first"}, 64'(first_i), 64'(v.first_inst));
    check({v.name, "_last"}, 64'(last_i), 64'(v.last_inst));
    check({v.name, "_done_edge"}, 64'(done_at), 64'(v.done_edge));
    check({v.name, "_busy_cycles"}, 64'(busy_cnt), 64'(v.done_edge));
    for (int n = 0; n < 8; n++)
      if (v.mask[n]) check({v.name, "_bank"}, 64'(bank[n]), 64'(v.data[8*n +: 8]));
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"m05", 8'h05, 64'h0000_0000_003C_00AB, 12'h1AB, 12'h33C, GAP ? 3 : 2, GAP ? 4 : 3};
    vecs[1] = '{"mFF", 8'hFF, 64'h0706_0504_0302_0100, 12'h100, 12'h807, GAP ? 15 : 8, GAP ? 16 : 9};
    vecs[2] = '{"m00", 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 12'h000, 12'h000, 0, 2};
    vecs[3] = '{"m03", 8'h03, 64'h0000_0000_0000_2211, 12'h111, 12'h222, GAP ? 3 : 2, GAP ? 4 : 3};
    vecs[4] = '{"m80", 8'h80, 64'h5A00_0000_0000_0000, 12'h85A, 12'h85A, 1, 2};

    repeat (3) step();
    check("reset_outputs", 64'(cur), 64'(0));
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start held high: a second capture happens only after Done returns to Idle.
    begin
      int dn = 0;
      start = 1'b1; mask = 8'h80; data = 64'hC400_0000_0000_0000;
      step();
      check("hold_accept", 64'(cur), 64'({12'h000, 3'b010}));
      mask = 8'hFF; data = 64'h7766_5544_3322_1199;
      step(); check("hold_ld7", 64'(cur), 64'({12'h8C4, 3'b110}));
      step(); check("hold_done", 64'(cur), 64'({12'h000, 3'b001}));
      step(); check("hold_done_ignores", 64'(cur), 64'({12'h000, 3'b000}));
      step(); check("hold_reaccept", 64'(cur), 64'({12'h000, 3'b010}));
      step(); check("hold_second_ld0", 64'(cur), 64'({12'h199, 3'b110}));
      start = 1'b0;
      for (int j = 0; j < 40 && dn == 0; j++) begin
        step();
        if (done) dn++;
      end
      step();
      check("hold_second_done", 64'(dn), 64'(1));
    end

    // Asynchronous reset after the second load of mask 0F.
    begin
      int stray = 0;
      start = 1'b1; mask = 8'h0F; data = 64'h0000_0000_4433_2211;
      step(); start = 1'b0;
      step(); check("rst_ld0", 64'(cur), 64'({12'h111, 3'b110}));
      step(); check("rst_ld1", 64'(cur), 64'({12'h222, 3'b110}));
      #2 reset = 1'b0;
      #1 check("rst_async_clear", 64'(cur), 64'(0));
      step(); step();
      reset = 1'b1;
      for (int j = 0; j < 10; j++) begin
        step();
        if (inst_en || busy || done) stray++;
      end
      check("rst_no_resume", 64'(stray), 64'(0));
    end

    // First edge after release accepts start.
    reset = 1'b0;
    step();
    reset = 1'b1; start = 1'b1; mask = 8'h01; data = 64'h55;
    step(); check("release_accept", 64'(cur), 64'({12'h000, 3'b010}));
    start = 1'b0;
    step(); check("release_ld0", 64'(cur), 64'({12'h155, 3'b110}));
    step(); check("release_done", 64'(cur), 64'({12'h000, 3'b001}));
    step();

    // Random transactions against the model, with noisy inputs while busy.
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  m;
      logic [63:0] d;
      int idle_n;
      idle_n = int'($urandom_range(0, 2));
      for (int j = 0; j < idle_n; j++) begin
        start = 1'b0; mask = 8'($urandom); data = {$urandom, $urandom};
        step();
        check("rand_idle", 64'(cur), 64'(0));
      end
      case ($urandom_range(0, 5))
        0:       m = 8'h00;
        1:       m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      d = {$urandom, $urandom};
      build_expected(m, d);
      start = 1'b1; mask = m; data = d;
      foreach (exp_q[j]) begin
        step();
        check($sformatf("rand_t%0d_e%0d", t, j), 64'(cur), 64'(exp_q[j]));
        start = 1'($urandom); mask = 8'($urandom); data = {$urandom, $urandom};
      end
    end
    start = 1'b0;
    step();
    check("inst_legal", 64'(bad_inst), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
